ltc2992_poll_sched: RTL and testbench

- Sequencer that owns the I2C read engine and sweeps a fixed LTC2992 register list: SENSE1, ΔSENSE1, ADIN1, SENSE2, ΔSENSE2, ADIN2.
- Each slot is read as a 2-byte read. The result is stored in a 6-entry shadow bank with per-slot valid and error flags.
- Sweeps are started by a periodic timer or by a software trigger.
- Sits between the system register file and the I2C read engine. Drives the engine's enable, address, word-address and byte-count inputs, and consumes its done pulse and read data.

---
 rtl/ltc2992_pkg.sv | 37 +++
 rtl/ltc2992_poll_sched_poll_timer.sv | 33 +++
 rtl/ltc2992_poll_sched.sv | 172 +++++++++++++++++
 tb/tb_ltc2992_poll_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltc2992_pkg.sv
// rtl/ltc2992_pkg.sv - shared LTC2992 constants, slot types and sequencer state encoding
package ltc2992_pkg;

    localparam int NUM_SLOTS = 6;

    typedef logic [2:0] slot_idx_t;

    // LTC2992 register addresses (MSB byte of each 2-byte result)
    localparam logic [7:0] REG_SENSE1  = 8'h14;
    localparam logic [7:0] REG_DSENSE1 = 8'h1E;
    localparam logic [7:0] REG_ADIN1   = 8'h28;
    localparam logic [7:0] REG_SENSE2  = 8'h46;
    localparam logic [7:0] REG_DSENSE2 = 8'h50;
    localparam logic [7:0] REG_ADIN2   = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_BUSY,
        ST_GAP,
        ST_END
    } state_t;

    function automatic logic [7:0] slot_addr(input slot_idx_t idx);
        case (idx)
            3'd0:    slot_addr = REG_SENSE1;
            3'd1:    slot_addr = REG_DSENSE1;
            3'd2:    slot_addr = REG_ADIN1;
            3'd3:    slot_addr = REG_SENSE2;
            3'd4:    slot_addr = REG_DSENSE2;
            3'd5:    slot_addr = REG_ADIN2;
            default: slot_addr = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ltc2992_poll_sched_poll_timer.sv
// rtl/ltc2992_poll_sched_poll_timer.sv - free-running period counter with wrap pulse
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : count enable
//   clr        : synchronous clear (wins over en)
//   wrap       : high in the cycle the counter sits at PERIOD_CYC-1 (combinational)
module poll_timer #(
    parameter int PERIOD_CYC = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int W = (PERIOD_CYC > 2) ? $clog2(PERIOD_CYC) : 1;

    logic [W-1:0] cnt;

    assign wrap = en && !clr && (cnt == W'(PERIOD_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ltc2992_poll_sched.sv
// rtl/ltc2992_poll_sched.sv - LTC2992 register sweep sequencer with shadow bank
// Ports:
//   I_clk, I_rst_n          : clock, async active-low reset
//   I_auto_en, I_trig       : periodic sweep enable, one-shot sweep request
//   I_slot_mask             : per-slot read enable, sampled in SELECT
//   I_done_flag, I_read_data: read engine completion pulse and 16-bit result
//   O_recv_en, O_dev_addr, O_word_addr, O_byte : read engine controls
//   O_data, O_valid, O_err, O_err_cnt          : shadow bank and status
//   O_update, O_busy, O_sweep_done             : sweep progress
module ltc2992_poll_sched
    import ltc2992_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h6F,
    parameter int         PERIOD_CYC  = 100000,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         GAP_CYC     = 4
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_auto_en,
    input  logic        I_trig,
    input  logic [5:0]  I_slot_mask,
    input  logic        I_done_flag,
    input  logic [15:0] I_read_data,
    output logic        O_recv_en,
    output logic [6:0]  O_dev_addr,
    output logic [7:0]  O_word_addr,
    output logic [1:0]  O_byte,
    output logic [95:0] O_data,
    output logic [5:0]  O_valid,
    output logic [5:0]  O_err,
    output logic [7:0]  O_err_cnt,
    output logic        O_update,
    output logic        O_busy,
    output logic        O_sweep_done
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GW = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

    state_t       state, state_n;
    slot_idx_t    idx;
    logic [TW-1:0] tmo;
    logic [GW-1:0] gap;
    logic         pending;
    logic         period_wrap;
    logic         start_req;
    logic         idx_out;
    logic         tmo_hit;
    logic         gap_last;
    logic         restart;

    assign O_dev_addr = DEV_ADDR;
    assign O_byte     = 2'd2;

    poll_timer #(
        .PERIOD_CYC(PERIOD_CYC)
    ) u_timer (
        .clk  (I_clk),
        .rst_n(I_rst_n),
        .en   (I_auto_en),
        .clr  (~I_auto_en),
        .wrap (period_wrap)
    );

    assign start_req = period_wrap | I_trig;
    assign idx_out   = (idx >= slot_idx_t'(NUM_SLOTS));
    assign tmo_hit   = (tmo == TW'(TIMEOUT_CYC - 1));
    assign gap_last  = (gap == GW'(GAP_CYC - 1));
    // A request arriving in END is folded into the restart rather than lost.
    assign restart   = pending | start_req;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (start_req) state_n = ST_SELECT;
            ST_SELECT: begin
                if (idx_out)                state_n = ST_END;
                else if (I_slot_mask[idx])  state_n = ST_ISSUE;
            end
            ST_ISSUE:  state_n = ST_BUSY;
            ST_BUSY:   if (I_done_flag || tmo_hit) state_n = ST_GAP;
            ST_GAP:    if (gap_last) state_n = ST_SELECT;
            ST_END:    state_n = restart ? ST_SELECT : ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            idx          <= '0;
            tmo          <= '0;
            gap          <= '0;
            pending      <= 1'b0;
            O_recv_en    <= 1'b0;
            O_word_addr  <= 8'h00;
            O_data       <= '0;
            O_valid      <= '0;
            O_err        <= '0;
            O_err_cnt    <= 8'h00;
            O_update     <= 1'b0;
            O_busy       <= 1'b0;
            O_sweep_done <= 1'b0;
        end else begin
            O_update     <= 1'b0;
            O_sweep_done <= 1'b0;

            if (start_req && state != ST_IDLE && state != ST_END) begin
                pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        idx    <= '0;
                        O_busy <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (!idx_out) begin
                        if (I_slot_mask[idx]) O_word_addr <= slot_addr(idx);
                        else                  idx <= idx + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    O_recv_en <= 1'b1;
                    tmo       <= '0;
                end
                ST_BUSY: begin
                    tmo <= tmo + 1'b1;
                    if (I_done_flag) begin
                        O_data[{idx, 4'b0000} +: 16] <= I_read_data;
                        O_valid[idx] <= 1'b1;
                        O_err[idx]   <= 1'b0;
                        O_update     <= 1'b1;
                        O_recv_en    <= 1'b0;
                        gap          <= '0;
                    end else if (tmo_hit) begin
                        O_recv_en  <= 1'b0;
                        O_err[idx] <= 1'b1;
                        if (O_err_cnt != 8'hFF) O_err_cnt <= O_err_cnt + 1'b1;
                        gap        <= '0;
                    end
                end
                ST_GAP: begin
                    // Engine held disabled so it re-initialises between reads
                    gap <= gap + 1'b1;
                    if (gap_last) idx <= idx + 1'b1;
                end
                ST_END: begin
                    O_sweep_done <= 1'b1;
                    if (restart) begin
                        pending <= 1'b0;
                        idx     <= '0;
                    end else begin
                        O_busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ltc2992_poll_sched.sv
// tb/tb_ltc2992_poll_sched.sv - self-checking bench for ltc2992_poll_sched
module tb_ltc2992_poll_sched;

    localparam int TMO = 100;
    localparam int PER = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        auto_en = 1'b0;
    logic        trig = 1'b0;
    logic [5:0]  mask = 6'h00;
    logic        done_flag = 1'b0;
    logic [15:0] read_data = 16'h0000;
    logic        recv_en;
    logic [6:0]  dev_addr;
    logic [7:0]  word_addr;
    logic [1:0]  nbyte;
    logic [95:0] data;
    logic [5:0]  valid;
    logic [5:0]  err;
    logic [7:0]  err_cnt;
    logic        update;
    logic        busy;
    logic        sweep_done;

    always #5 clk = ~clk;

    ltc2992_poll_sched #(
        .DEV_ADDR(7'h6F), .PERIOD_CYC(PER), .TIMEOUT_CYC(TMO), .GAP_CYC(4)
    ) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_auto_en(auto_en), .I_trig(trig),
        .I_slot_mask(mask), .I_done_flag(done_flag), .I_read_data(read_data),
        .O_recv_en(recv_en), .O_dev_addr(dev_addr), .O_word_addr(word_addr),
        .O_byte(nbyte), .O_data(data), .O_valid(valid), .O_err(err),
        .O_err_cnt(err_cnt), .O_update(update), .O_busy(busy),
        .O_sweep_done(sweep_done)
    );

    typedef struct {
        bit          rst;
        logic [5:0]  mask;
        int          hang;
        int          lat;
        logic [15:0] base;
        logic [5:0]  exp_valid;
        logic [5:0]  exp_err;
        logic [7:0]  exp_cnt;
        int          exp_upd;
    } vec_t;

    logic [7:0] addr_tab [6] = '{8'h14, 8'h1E, 8'h28, 8'h46, 8'h50, 8'h5A};

    int checks = 0;
    int errors = 0;

    // engine model / monitor state
    int          cyc = 0, hi_cnt = 0, low_len = 0, min_low = 1000;
    int          upd_cnt = 0, sd_cnt = 0, busy_fall_cnt = 0;
    bit          have_fall = 0, stray = 0;
    logic        prev_recv = 1'b0, prev_busy = 1'b0;
    logic [7:0]  issue_q [$];
    int          run_q [$];
    int          rise_q [$];
    int          hang = 7, lat = 3;
    logic [15:0] base = 16'h0000;

    // expected shadow bank
    logic [15:0] exp_data [6];
    logic [5:0]  exp_valid;
    logic [5:0]  exp_err;
    logic [7:0]  exp_cnt;

    function automatic int slot_of(input logic [7:0] a);
        for (int k = 0; k < 6; k++) if (addr_tab[k] == a) return k;
        return 7;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        cyc++;
        if (recv_en) begin
            if (!prev_recv) begin
                issue_q.push_back(word_addr);
                if (have_fall && low_len < min_low) min_low = low_len;
            end
            hi_cnt++;
        end else begin
            if (prev_recv) begin
                run_q.push_back(hi_cnt);
                have_fall = 1;
                low_len = 0;
            end
            hi_cnt = 0;
            low_len++;
        end
        done_flag = (recv_en && hi_cnt == lat && slot_of(word_addr) != hang) || stray;
        read_data = base + 16'(slot_of(word_addr));
        upd_cnt += int'(update);
        sd_cnt  += int'(sweep_done);
        if (busy && !prev_busy) rise_q.push_back(cyc);
        if (!busy && prev_busy) busy_fall_cnt++;
        prev_recv = recv_en;
        prev_busy = busy;
    end

    task automatic clear_model();
        for (int k = 0; k < 6; k++) exp_data[k] = 16'h0000;
        exp_valid = '0;
        exp_err   = '0;
        exp_cnt   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_model();
    endtask

    task automatic clear_mon();
        issue_q.delete();
        run_q.delete();
        upd_cnt = 0;
        sd_cnt = 0;
        busy_fall_cnt = 0;
        min_low = 1000;
        have_fall = 0;
    endtask

    task automatic wait_busy_low(input string name, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 0);
    endtask

    task automatic wait_rise(input string name, input int cnt, input int budget);
        int n = 0;
        while (rise_q.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, rise_q.size() >= cnt, 1);
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic run_row(input vec_t v);
        int n_exp = 0;
        int hang_pos = -1;
        logic [95:0] exp_pack;
        if (v.rst) do_reset();
        mask = v.mask; hang = v.hang; lat = v.lat; base = v.base;
        clear_mon();
        pulse_trig();
        wait_busy_low("sweep_end", 3000);
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            if (v.mask[k]) begin
                if (n_exp < issue_q.size()) chk("issue_addr", issue_q[n_exp], addr_tab[k]);
                if (k == v.hang) begin
                    hang_pos = n_exp;
                    exp_err[k] = 1'b1;
                    if (exp_cnt != 8'hFF) exp_cnt++;
                end else begin
                    exp_valid[k] = 1'b1;
                    exp_err[k]   = 1'b0;
                    exp_data[k]  = v.base + 16'(k);
                end
                n_exp++;
            end
        end
        for (int k = 0; k < 6; k++) exp_pack[k*16 +: 16] = exp_data[k];
        chk("issue_count", issue_q.size(), n_exp);
        chk("update_count", upd_cnt, v.exp_upd);
        chk("sweep_done_count", sd_cnt, 1);
        chk("valid", valid, v.exp_valid);
        chk("valid_model", valid, exp_valid);
        chk("err", err, v.exp_err);
        chk("err_cnt", err_cnt, v.exp_cnt);
        chk("data", data, exp_pack);
        if (n_exp >= 2) chk("gap_ge4", min_low >= 4, 1);
        if (hang_pos >= 0 && hang_pos < run_q.size()) chk("timeout_len", run_q[hang_pos], TMO);
        if (v.lat == TMO && run_q.size() > 0) chk("coincide_len", run_q[0], TMO);
    endtask

    vec_t tab [6];

    initial begin
        tab[0] = '{1, 6'h3F, 7, 3,   16'hA5C0, 6'h3F, 6'h00, 8'd0, 6};
        tab[1] = '{1, 6'h21, 7, 3,   16'h1200, 6'h21, 6'h00, 8'd0, 2};
        tab[2] = '{0, 6'h3F, 3, 3,   16'h3400, 6'h37, 6'h08, 8'd1, 5};
        tab[3] = '{0, 6'h08, 7, 3,   16'h5600, 6'h3F, 6'h00, 8'd1, 1};
        tab[4] = '{0, 6'h00, 7, 3,   16'h7800, 6'h3F, 6'h00, 8'd1, 0};
        tab[5] = '{0, 6'h02, 7, TMO, 16'h9A00, 6'h3F, 6'h00, 8'd1, 1};
        clear_model();

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_recv_en", recv_en, 0);
        chk("rst_dev_addr", dev_addr, 7'h6F);
        chk("rst_byte", nbyte, 2);
        chk("rst_word_addr", word_addr, 0);
        chk("rst_data", data, 0);
        chk("rst_flags", {valid, err, err_cnt}, 0);
        chk("rst_pulses", {update, busy, sweep_done}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // done outside BUSY is ignored
        stray = 1;
        @(negedge clk);
        stray = 0;
        repeat (3) @(negedge clk);
        chk("stray_update", upd_cnt, 0);
        chk("stray_valid", valid, 0);

        for (int i = 0; i < 6; i++) begin
            run_row(tab[i]);
            if (i == 0) chk("slot2_data", data[47:32], 16'hA5C2);
        end

        // periodic sweeps and a trigger merged into a back-to-back sweep
        mask = 6'h3F; hang = 7; lat = 3; base = 16'hC000;
        rise_q.delete();
        auto_en = 1'b1;
        wait_rise("period_rise1", 1, PER + 100);
        wait_busy_low("period_end1", 3000);
        wait_rise("period_rise2", 2, PER + 100);
        if (rise_q.size() >= 2) chk("period_interval1", rise_q[1] - rise_q[0], PER);
        clear_mon();
        repeat (20) @(negedge clk);
        pulse_trig();
        wait_busy_low("b2b_end", 3000);
        chk("b2b_sweep_done", sd_cnt, 2);
        chk("b2b_updates", upd_cnt, 12);
        chk("b2b_issues", issue_q.size(), 12);
        chk("b2b_busy_held", busy_fall_cnt, 1);
        wait_rise("period_rise3", 3, PER + 100);
        if (rise_q.size() >= 3) chk("period_interval2", rise_q[2] - rise_q[1], PER);
        auto_en = 1'b0;
        wait_busy_low("period_end3", 3000);

        // async reset while BUSY
        mask = 6'h3F; hang = 0; lat = 3;
        pulse_trig();
        begin
            int n = 0;
            while (recv_en !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("busy_reached", recv_en, 1);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_recv_en", recv_en, 0);
        chk("async_flags", {valid, err, err_cnt}, 0);
        chk("async_busy", busy, 0);
        chk("async_data", data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        run_row('{0, 6'h3F, 7, 3, 16'hD000, 6'h3F, 6'h00, 8'd0, 6});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
